if_prefetch_fetch: RTL and testbench

Parametrised successor to the single-request fetch stage. Keeps up to MAX_OUT instruction requests in flight on the SRAM-like inst_* bus and buffers returned words, tagged with their PC, in a DEPTH-entry in-order queue. Decode consumes the queue head. Redirects and exceptions flush the queue and discard stale in-flight responses. Sits between the PC-select logic (branch/jump/EPC) and the IF/ID register.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/if_prefetch_fetch_if.sv | 42 ++++
 rtl/fetch_sync_fifo.sv | 58 +++++
 rtl/if_prefetch_fetch.sv | 120 ++++++++++++
 tb/tb_if_prefetch_fetch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the prefetching fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VEC   = 32'hbfc0_0380;
  localparam logic [1:0]  SIZE_WORD = 2'b10;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_fetch_if.sv
// Signal bundle between the fetch stage, its redirect sources, decode and the inst_* SRAM-like bus.
interface if_prefetch_fetch_if #(
  parameter int WIDTH = 32
);

  logic             exc_valid;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             deq;

  logic             out_valid;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_pc_add_4;
  logic             stall;

  logic             inst_req;
  logic             inst_wr;
  logic [1:0]       inst_size;
  logic [WIDTH-1:0] inst_addr;
  logic [WIDTH-1:0] inst_wdata;
  logic [WIDTH-1:0] inst_rdata;
  logic             inst_addr_ok;
  logic             inst_data_ok;

  // Fetch-stage view.
  modport master (
    input  exc_valid, redirect_valid, redirect_pc, deq,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output out_valid, out_instr, out_pc, out_pc_add_4, stall,
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata
  );

  // Environment view: redirect sources, decode and the bus slave.
  modport slave (
    output exc_valid, redirect_valid, redirect_pc, deq,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  out_valid, out_instr, out_pc, out_pc_add_4, stall,
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata
  );

endinterface

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO with flush; push is ignored when full, pop when empty.
// Head data is combinational from storage, count/flags update one cycle after push/pop.
module fetch_sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_w(DEPTH)-1:0]    count
);

  localparam int             AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW   = cnt_w(DEPTH);
  localparam logic [AW-1:0]  LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

endmodule

// File: rtl/if_prefetch_fetch.sv
// Prefetching fetch stage: up to MAX_OUT requests in flight, returned words queued in order with their PC.
// data_ok -> out_valid is one cycle; issue stops while in-flight plus queued words would exceed DEPTH.
module if_prefetch_fetch #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter int               MAX_OUT  = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(fetch_pkg::RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(fetch_pkg::EXC_VEC)
) (
  input logic                 clk,
  input logic                 rst,
  if_prefetch_fetch_if.master fe
);

  import fetch_pkg::*;

  localparam int OW = cnt_w(MAX_OUT);
  localparam int QW = cnt_w(DEPTH);

  logic [WIDTH-1:0]   fpc;
  logic [OW-1:0]      outstanding;
  logic [OW-1:0]      drop_cnt;
  logic [QW-1:0]      q_count;
  logic               tag_full;
  logic               tag_empty;
  logic [WIDTH-1:0]   tag_head;
  logic               q_full;
  logic               q_empty;
  logic [2*WIDTH-1:0] q_head;

  logic flush;
  logic room;
  logic accept;
  logic resp;
  logic drop_now;
  logic q_push;
  logic q_pop;

  assign flush = fe.exc_valid || fe.redirect_valid;

  // Reserving queue space at issue time means a returned word always has a slot.
  assign room = (int'(outstanding) < MAX_OUT)
             && ((int'(outstanding) + int'(q_count)) < DEPTH)
             && !tag_full && !q_full;

  assign fe.inst_req = !rst && !flush && room;
  assign accept      = fe.inst_req && fe.inst_addr_ok;
  assign resp        = fe.inst_data_ok && !tag_empty;
  assign drop_now    = resp && (drop_cnt != '0);
  assign q_push      = resp && !drop_now && !flush;
  assign q_pop       = fe.deq && !q_empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc <= RESET_PC;
    end else if (fe.exc_valid) begin
      fpc <= EXC_VEC;
    end else if (fe.redirect_valid) begin
      fpc <= fe.redirect_pc;
    end else if (accept) begin
      fpc <= fpc + WIDTH'(4);
    end
  end

  // Every request still in flight after a flush is stale; a response in the flush cycle is already gone.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= resp ? outstanding - 1'b1 : outstanding;
    end else if (drop_now) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // The tag FIFO occupancy is the outstanding-request count; tags are never flushed.
  fetch_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_dat (fpc),
    .pop      (resp),
    .flush    (1'b0),
    .head_dat (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (outstanding)
  );

  fetch_sync_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_dat ({tag_head, fe.inst_rdata}),
    .pop      (q_pop),
    .flush    (flush),
    .head_dat (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign fe.out_valid    = !q_empty;
  assign fe.stall        = q_empty;
  assign fe.out_pc       = q_head[2*WIDTH-1:WIDTH];
  assign fe.out_instr    = q_head[WIDTH-1:0];
  assign fe.out_pc_add_4 = q_head[2*WIDTH-1:WIDTH] + WIDTH'(4);

  assign fe.inst_wr    = 1'b0;
  assign fe.inst_size  = SIZE_WORD;
  assign fe.inst_addr  = fpc;
  assign fe.inst_wdata = '0;

endmodule

// File: tb/tb_if_prefetch_fetch.sv
// Scoreboard bench for if_prefetch_fetch: directed scenarios, bus model returns ~addr one cycle after accept.
module tb_if_prefetch_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_prefetch_fetch_if #(.WIDTH(32)) fe ();

  if_prefetch_fetch #(
    .WIDTH    (32),
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (32'hbfc0_0000),
    .EXC_VEC  (32'hbfc0_0380)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fe  (fe)
  );

  exp_t        sb[$];
  logic [31:0] pend[$];
  int          budget  = 0;
  bit          resp_en = 1'b0;
  int          n_chk   = 0;
  int          n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] pc4);
    exp_t e;
    e.pc    = pc;
    e.instr = ~pc;
    e.pc4   = pc4;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Bus slave: addr_ok while budget remains, data (~addr) returned in order one cycle after accept.
  initial begin
    bit          acc;
    bit          r;
    bit          rs;
    logic [31:0] a;
    fe.inst_addr_ok = 1'b0;
    fe.inst_data_ok = 1'b0;
    fe.inst_rdata   = '0;
    forever begin
      @(negedge clk);
      acc = fe.inst_req && fe.inst_addr_ok;
      a   = fe.inst_addr;
      r   = fe.inst_data_ok;
      rs  = rst;
      @(posedge clk);
      #1;
      if (rs) begin
        pend.delete();
      end else begin
        if (r && pend.size() > 0) void'(pend.pop_front());
        if (acc) begin
          pend.push_back(a);
          if (budget > 0) budget--;
        end
      end
      fe.inst_addr_ok = (budget > 0);
      fe.inst_data_ok = resp_en && (pend.size() > 0);
      fe.inst_rdata   = (pend.size() > 0) ? ~pend[0] : '0;
    end
  end

  // Monitor: every word decode consumes is compared against the scoreboard head.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && fe.out_valid && fe.deq && !fe.exc_valid && !fe.redirect_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got pc %h, expected no word", fe.out_pc);
        end else begin
          x = sb.pop_front();
          check("out_pc", fe.out_pc, x.pc);
          check("out_instr", fe.out_instr, x.instr);
          check("out_pc_add_4", fe.out_pc_add_4, x.pc4);
        end
      end
    end
  end

  task automatic do_reset();
    rst               = 1'b1;
    fe.deq            = 1'b0;
    fe.exc_valid      = 1'b0;
    fe.redirect_valid = 1'b0;
    budget            = 0;
    resp_en           = 1'b0;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    tick();
    fe.deq  = 1'b1;
    resp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sb.size() == 0 && pend.size() == 0 && !fe.out_valid) break;
    end
    repeat (3) tick();
    check({"drain_", nm}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    fe.deq            = 1'b0;
    fe.exc_valid      = 1'b0;
    fe.redirect_valid = 1'b0;
    fe.redirect_pc    = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_inst_req", {31'd0, fe.inst_req}, 32'd0);
    check("rst_out_valid", {31'd0, fe.out_valid}, 32'd0);
    check("rst_stall", {31'd0, fe.stall}, 32'd1);
    rst = 1'b0;

    // addr_ok held low: address and request stay put, nothing delivered
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_inst_addr", fe.inst_addr, 32'hbfc0_0000);
      check("hold_inst_req", {31'd0, fe.inst_req}, 32'd1);
      check("hold_out_valid", {31'd0, fe.out_valid}, 32'd0);
    end

    // streaming with deq always high
    tick();
    budget = 8;
    sb.push_back(mk(32'hbfc0_0000, 32'hbfc0_0004));
    sb.push_back(mk(32'hbfc0_0004, 32'hbfc0_0008));
    sb.push_back(mk(32'hbfc0_0008, 32'hbfc0_000c));
    sb.push_back(mk(32'hbfc0_000c, 32'hbfc0_0010));
    sb.push_back(mk(32'hbfc0_0010, 32'hbfc0_0014));
    sb.push_back(mk(32'hbfc0_0014, 32'hbfc0_0018));
    sb.push_back(mk(32'hbfc0_0018, 32'hbfc0_001c));
    sb.push_back(mk(32'hbfc0_001c, 32'hbfc0_0020));
    drain("stream");

    // fill the queue with no consumer
    do_reset();
    budget  = 5;
    resp_en = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("full_inst_req", {31'd0, fe.inst_req}, 32'd0);
    check("full_out_valid", {31'd0, fe.out_valid}, 32'd1);
    check("full_head_pc", fe.out_pc, 32'hbfc0_0000);
    tick();
    sb.push_back(mk(32'hbfc0_0000, 32'hbfc0_0004));
    fe.deq = 1'b1;
    tick();
    fe.deq = 1'b0;
    @(negedge clk);
    check("refill_inst_req", {31'd0, fe.inst_req}, 32'd1);
    check("refill_inst_addr", fe.inst_addr, 32'hbfc0_0010);
    sb.push_back(mk(32'hbfc0_0004, 32'hbfc0_0008));
    sb.push_back(mk(32'hbfc0_0008, 32'hbfc0_000c));
    sb.push_back(mk(32'hbfc0_000c, 32'hbfc0_0010));
    sb.push_back(mk(32'hbfc0_0010, 32'hbfc0_0014));
    drain("fill");

    // redirect with two requests in flight: both stale responses dropped
    do_reset();
    budget = 2;
    fe.deq = 1'b1;
    repeat (6) tick();
    fe.redirect_valid = 1'b1;
    fe.redirect_pc    = 32'h8000_1000;
    tick();
    fe.redirect_valid = 1'b0;
    budget = 2;
    sb.push_back(mk(32'h8000_1000, 32'h8000_1004));
    sb.push_back(mk(32'h8000_1004, 32'h8000_1008));
    drain("redirect");

    // exception wins over a simultaneous redirect; no request in the flush cycle
    tick();
    fe.exc_valid      = 1'b1;
    fe.redirect_valid = 1'b1;
    fe.redirect_pc    = 32'h1234_5678;
    @(negedge clk);
    check("flush_inst_req", {31'd0, fe.inst_req}, 32'd0);
    tick();
    fe.exc_valid      = 1'b0;
    fe.redirect_valid = 1'b0;
    @(negedge clk);
    check("exc_inst_addr", fe.inst_addr, 32'hbfc0_0380);
    check("exc_inst_req", {31'd0, fe.inst_req}, 32'd1);
    sb.push_back(mk(32'hbfc0_0380, 32'hbfc0_0384));
    budget = 1;
    drain("exc");

    // fetch PC wraps past the top of the address space
    tick();
    fe.redirect_valid = 1'b1;
    fe.redirect_pc    = 32'hffff_fffc;
    tick();
    fe.redirect_valid = 1'b0;
    budget = 2;
    sb.push_back(mk(32'hffff_fffc, 32'h0000_0000));
    sb.push_back(mk(32'h0000_0000, 32'h0000_0004));
    tick();
    tick();
    @(negedge clk);
    check("wrap_inst_addr", fe.inst_addr, 32'h0000_0000);
    drain("wrap");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
